// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the pipeline (port 0) and the network/debug unit (port 1).
// Optional ALU_ARB_PERF_EN adds grant and stall performance counters.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 16
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][DATA_W-1:0] req_rd_i,
  input  logic [1:0][DATA_W-1:0] req_rs_i,
  input  logic [1:0][OP_W-1:0]   req_op_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [DATA_W-1:0]      rsp_result_o,
  output logic                   rsp_jump_o,
  output logic [DATA_W-1:0]      alu_rd_o,
  output logic [DATA_W-1:0]      alu_rs_o,
  output logic [OP_W-1:0]        alu_op_o,
  input  logic [DATA_W-1:0]      alu_result_i,
  input  logic                   alu_jump_i
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]            grant_cnt0_o,
  output logic [31:0]            grant_cnt1_o,
  output logic [31:0]            stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              last_q;
  logic              owner_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rs_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] res_q;
  logic              jmp_q;

  logic win;
  logic accept;
  logic rsp_hs;

  // Winner: sole valid requester, or on a tie the one not granted last.
  always_comb begin
    if (&req_valid_i) begin
      win = ~last_q;
    end else begin
      win = req_valid_i[1];
    end
  end

  assign accept = |req_ready_o;
  assign rsp_hs = rsp_valid_o[owner_q]
                & rsp_ready_i[owner_q];

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state, valids and owner only.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state_q == S_IDLE) begin
      req_ready_o[win] = req_valid_i[win];
    end
    if (state_q == S_RESP) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
  end

  // Operand latches and arbitration history, loaded on accept.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rd_q    <= '0;
      rs_q    <= '0;
      op_q    <= '0;
    end else if (accept) begin
      last_q  <= win;
      owner_q <= win;
      rd_q    <= req_rd_i[win];
      rs_q    <= req_rs_i[win];
      op_q    <= req_op_i[win];
    end
  end

  // Result capture at the EXEC->RESP edge; held until the next op.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      res_q <= '0;
      jmp_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q <= alu_result_i;
      jmp_q <= alu_jump_i;
    end
  end

  assign alu_rd_o     = rd_q;
  assign alu_rs_o     = rs_q;
  assign alu_op_o     = op_q;
  assign rsp_result_o = res_q;
  assign rsp_jump_o   = jmp_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] gcnt0_q;
  logic [31:0] gcnt1_q;
  logic [31:0] scnt_q;

  // Accept counts per port and stalled-response cycles, all wrapping.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      scnt_q  <= '0;
    end else begin
      if (req_ready_o[0] & req_valid_i[0]) begin
        gcnt0_q <= gcnt0_q + 32'd1;
      end
      if (req_ready_o[1] & req_valid_i[1]) begin
        gcnt1_q <= gcnt1_q + 32'd1;
      end
      if ((state_q == S_RESP)
          && !rsp_ready_i[owner_q]) begin
        scnt_q <= scnt_q + 32'd1;
      end
    end
  end

  assign grant_cnt0_o = gcnt0_q;
  assign grant_cnt1_o = gcnt1_q;
  assign stall_cnt_o  = scnt_q;
`endif

endmodule
